// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with fill count, almost-full/almost-empty flags
// and an optional first-word-fall-through read port (define SYNC_FIFO_FWFT_EN).
module sync_fifo #(
   parameter int DATA_WIDTH    = 8,
   parameter int ADDR_WIDTH    = 4,
   parameter int AFULL_THRESH  = 12,
   parameter int AEMPTY_THRESH = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  wr_en,
   output logic                  full,
   output logic                  almost_full,
   output logic                  overflow,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  empty,
   output logic                  almost_empty,
   output logic                  underflow,
   output logic [ADDR_WIDTH:0]   count
);
   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AFULL_THRESH);
   localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AEMPTY_THRESH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
   logic                  overflow_q, overflow_d, underflow_q, underflow_d;
   logic                  wr_acc, rd_acc;

   // Flags decode registered count only, so no request input reaches an output.
   assign count        = count_q;
   assign empty        = count_q == '0;
   assign full         = count_q == DEPTH_C;
   assign almost_full  = count_q >= AF_C;
   assign almost_empty = count_q <= AE_C;
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

   always_comb begin
      wr_acc      = wr_en && !full;
      rd_acc      = rd_en && !empty;
      wr_ptr_d    = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d    = rd_acc ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d     = (wr_acc && !rd_acc) ? count_q + 1'b1 :
                    (rd_acc && !wr_acc) ? count_q - 1'b1 : count_q;
      overflow_d  = wr_en && !wr_acc;
      underflow_d = rd_en && !rd_acc;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && wr_acc) mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= wr_data;
   end

`ifdef SYNC_FIFO_FWFT_EN
   // Head entry is shown directly; rd_en only pops it.
   assign rd_data = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
`else
   logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

   assign rd_data = rd_data_q;

   always_comb rd_data_d = rd_acc ? mem_q[rd_ptr_q[ADDR_WIDTH-1:0]] : rd_data_q;

   always_ff @(posedge clk) begin
      if (rst) rd_data_q <= '0;
      else     rd_data_q <= rd_data_d;
   end
`endif
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed scoreboard bench for sync_fifo (DEPTH=4, AF=3, AE=1);
// covers FWFT behaviour too when SYNC_FIFO_FWFT_EN is defined.
module tb_sync_fifo;
   logic       clk = 1'b0, rst = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
   logic [7:0] wr_data = '0, rd_data;
   logic       full, almost_full, overflow, empty, almost_empty, underflow;
   logic [2:0] count;

   int         vecs = 0, errs = 0, mcount = 0;
   logic [7:0] mq[$], exp_q[$];
   logic [7:0] hold_exp = '0;
   logic       pend_rd = 1'b0, e_ovf = 1'b0, e_udf = 1'b0;

   sync_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .AFULL_THRESH(3), .AEMPTY_THRESH(1)) dut (
      .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en), .full(full),
      .almost_full(almost_full), .overflow(overflow), .rd_en(rd_en), .rd_data(rd_data),
      .empty(empty), .almost_empty(almost_empty), .underflow(underflow), .count(count)
   );

   always #5 clk = ~clk;

   function automatic void chk(input string name, input int act, input int exp);
      vecs++;
      if (act != exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

`ifndef SYNC_FIFO_FWFT_EN
   // Monitor: one cycle after an accepted read, rd_data must be the next queued word.
   always @(posedge clk) begin
      if (pend_rd) begin
         #2;
         if (exp_q.size() == 0) chk("rd_data_unexpected", 1, 0);
         else begin
            hold_exp = exp_q.pop_front();
            chk("rd_data", int'(rd_data), int'(hold_exp));
         end
      end
   end
`endif

   task automatic check_state(input string tag);
      chk({tag, ":count"}, int'(count), mcount);
      chk({tag, ":empty"}, int'(empty), int'(mcount == 0));
      chk({tag, ":full"}, int'(full), int'(mcount == 4));
      chk({tag, ":almost_full"}, int'(almost_full), int'(mcount >= 3));
      chk({tag, ":almost_empty"}, int'(almost_empty), int'(mcount <= 1));
      chk({tag, ":overflow"}, int'(overflow), int'(e_ovf));
      chk({tag, ":underflow"}, int'(underflow), int'(e_udf));
`ifdef SYNC_FIFO_FWFT_EN
      if (mcount != 0) chk({tag, ":fwft_head"}, int'(rd_data), int'(mq[0]));
`else
      chk({tag, ":rd_hold"}, int'(rd_data), int'(hold_exp));
`endif
   endtask

   // Issue one cycle of stimulus from a negedge; returns at the following negedge.
   task automatic cyc(input string tag, input logic w, input logic [7:0] d, input logic r);
      logic wa, ra;
      wa = w && mcount != 4;
      ra = r && mcount != 0;
      if (ra) exp_q.push_back(mq.pop_front());
      if (wa) mq.push_back(d);
      mcount = mcount + int'(wa) - int'(ra);
      e_ovf = w && !wa;
      e_udf = r && !ra;
      wr_en = w; wr_data = d; rd_en = r; pend_rd = ra;
      @(posedge clk);
      @(negedge clk);
      wr_en = 1'b0; rd_en = 1'b0; pend_rd = 1'b0;
      check_state(tag);
   endtask

   task automatic do_reset(input int cycles);
      rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; pend_rd = 1'b0;
      repeat (cycles) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      mq.delete(); exp_q.delete();
      mcount = 0; hold_exp = '0; e_ovf = 1'b0; e_udf = 1'b0;
   endtask

   initial begin
      @(negedge clk);
      do_reset(2);
      check_state("reset");
`ifndef SYNC_FIFO_FWFT_EN
      chk("reset:rd_data_zero", int'(rd_data), 8'h00);
`endif
      cyc("fill0", 1'b1, 8'hA0, 1'b0);
      chk("fill0:hand_ae", int'(almost_empty), 1);
      cyc("fill1", 1'b1, 8'hA1, 1'b0);
      chk("fill1:hand_ae", int'(almost_empty), 0);
      cyc("fill2", 1'b1, 8'hA2, 1'b0);
      chk("fill2:hand_af", int'(almost_full), 1);
      cyc("fill3", 1'b1, 8'hA3, 1'b0);
      chk("fill3:hand_full", int'(full), 1);
      cyc("ovf", 1'b1, 8'hFF, 1'b0);
      chk("ovf:hand_pulse", int'(overflow), 1);
      chk("ovf:hand_count", int'(count), 4);
      for (int i = 0; i < 4; i++) cyc("drain", 1'b0, 8'h00, 1'b1);
      chk("drain:hand_empty", int'(empty), 1);
      chk("drain:hand_ovf_clear", int'(overflow), 0);
      cyc("udf", 1'b1, 8'h55, 1'b1);
      chk("udf:hand_pulse", int'(underflow), 1);
      chk("udf:hand_count", int'(count), 1);
      cyc("udf_read", 1'b0, 8'h00, 1'b1);
      chk("udf_read:hand_udf_clear", int'(underflow), 0);
      cyc("pre_wrap0", 1'b1, 8'hB0, 1'b0);
      cyc("pre_wrap1", 1'b1, 8'hB1, 1'b0);
      for (int i = 0; i < 20; i++) cyc("wrap", 1'b1, 8'hC0 + 8'(i), 1'b1);
      chk("wrap:hand_count", int'(count), 2);
      cyc("pre_rst", 1'b1, 8'hD0, 1'b0);
      chk("pre_rst:hand_count", int'(count), 3);
      do_reset(1);
      check_state("mid_reset");
      chk("mid_reset:hand_empty", int'(empty), 1);
      cyc("w3c", 1'b1, 8'h3C, 1'b0);
`ifdef SYNC_FIFO_FWFT_EN
      chk("fwft:hand_3c", int'(rd_data), 8'h3C);
      chk("fwft:hand_not_empty", int'(empty), 0);
      cyc("fwft_pop", 1'b0, 8'h00, 1'b1);
`else
      cyc("r3c", 1'b0, 8'h00, 1'b1);
      chk("r3c:hand_3c", int'(rd_data), 8'h3C);
`endif
      chk("end:scoreboard_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
